// File: rtl/sd_reg_arbiter.sv
// sd_reg_arbiter
// Round-robin arbiter that shares one SD host register-bank port between
// N_REQ internal requesters (0=host bus, 1=ADMA, 2=CMD, 3=DAT). One owner is
// granted at a time. Its address, data and strobes are muxed onto the register
// port, and read data is returned with a one-cycle ack per beat. A locked
// owner may issue back-to-back beats, up to MAX_HOLD beats per grant.
//
// Ports
//   CLK        clock, all state on rising edge
//   RESET      asynchronous active-low reset
//   req        per-requester access request (level, held until ack)
//   lock       per-requester burst lock (keep grant after current beat)
//   we         per-requester write(1)/read(0)
//   addr       flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata      flattened write data, requester i at [i*DATA_W +: DATA_W]
//   gnt        one-hot current owner (registered)
//   ack        one-cycle beat-complete pulse (registered)
//   rdata      read data, valid in the ack cycle, holds otherwise (registered)
//   reg_addr   register bank address (combinational from owner)
//   reg_wdata  register bank write data (combinational from owner)
//   reg_we     register bank write strobe (combinational)
//   reg_re     register bank read strobe (combinational)
//   reg_rdata  register bank read data, combinational from reg_addr
module sd_reg_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           lock,
  input  logic [N_REQ-1:0]           we,
  input  logic [N_REQ*ADDR_W-1:0]    addr,
  input  logic [N_REQ*DATA_W-1:0]    wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           ack,
  output logic [DATA_W-1:0]          rdata,
  output logic [ADDR_W-1:0]          reg_addr,
  output logic [DATA_W-1:0]          reg_wdata,
  output logic                       reg_we,
  output logic                       reg_re,
  input  logic [DATA_W-1:0]          reg_rdata
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]        state_q,    state_d;
  logic [IDX_W-1:0]  owner_q,    owner_d;
  logic [IDX_W-1:0]  rr_ptr_q,   rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [N_REQ-1:0]  gnt_d;
  logic [N_REQ-1:0]  ack_d;
  logic [DATA_W-1:0] rdata_d;

  logic              owner_req;
  logic              owner_lock;
  logic              owner_we;
  logic [ADDR_W-1:0] owner_addr;
  logic [DATA_W-1:0] owner_wdata;
  logic              beat;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;
  logic              release_own;
  logic [IDX_W-1:0]  owner_next;

  // Owner-side view of the requester inputs
  always_comb begin
    owner_req   = req[owner_q];
    owner_lock  = lock[owner_q];
    owner_we    = we[owner_q];
    owner_addr  = addr[32'(owner_q)*ADDR_W +: ADDR_W];
    owner_wdata = wdata[32'(owner_q)*DATA_W +: DATA_W];
  end

  // A beat issues whenever the registered owner is requesting
  assign beat = (state_q == ST_OWN) && owner_req;

  // Register-port mux; parked at zero when no beat is issuing
  always_comb begin
    reg_addr  = '0;
    reg_wdata = '0;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    if (beat) begin
      reg_addr  = owner_addr;
      reg_wdata = owner_wdata;
      reg_we    = owner_we;
      reg_re    = ~owner_we;
    end
  end

  // Round-robin search starting at rr_ptr
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + 32'(k)) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    gnt_d       = gnt;
    ack_d       = '0;
    rdata_d     = rdata;
    release_own = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          state_d    = ST_OWN;
          owner_d    = win_idx;
          gnt_d      = N_REQ'(1) << win_idx;
          beat_cnt_d = '0;
        end
      end

      ST_OWN: begin
        if (beat) begin
          ack_d = N_REQ'(1) << owner_q;
          if (!owner_we) begin
            rdata_d = reg_rdata;
          end
          beat_cnt_d = (beat_cnt_q == CNT_W'(MAX_HOLD)) ? beat_cnt_q
                                                         : beat_cnt_q + 1'b1;
          // Retain only while locked and this beat leaves hold budget
          if (!(owner_lock && ((32'(beat_cnt_q) + 32'd1) < MAX_HOLD))) begin
            release_own = 1'b1;
          end
        end else if (!owner_lock) begin
          release_own = 1'b1;
        end

        if (release_own) begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          rr_ptr_d = owner_next;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      gnt        <= '0;
      ack        <= '0;
      rdata      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      gnt        <= gnt_d;
      ack        <= ack_d;
      rdata      <= rdata_d;
    end
  end

  // Structural invariants of the arbiter outputs
  a_gnt_onehot: assert property (@(posedge CLK) disable iff (!RESET) $onehot0(gnt));
  a_ack_onehot: assert property (@(posedge CLK) disable iff (!RESET) $onehot0(ack));
  a_strobe_excl: assert property (@(posedge CLK) disable iff (!RESET) !(reg_we && reg_re));

endmodule
